// File: rtl/hdx_line_ctrl.sv
// Half-duplex single-wire line controller: drive a word MSB-first, release the line, then sample a reply.
// Build option: define HDX_PARITY_EN to append/check an even-parity bit in each direction.
module hdx_line_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TURN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_err,
  output logic             pad_en,
  output logic             pad_o,
  input  logic             pad_i
);

`ifdef HDX_PARITY_EN
  localparam int unsigned NB = WIDTH + 1;
`else
  localparam int unsigned NB = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam int unsigned TW = (TURN > 1) ? $clog2(TURN) : 1;
  localparam logic [CW-1:0] NB_LAST   = CW'(NB - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_TURN,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   bit_cnt;
  logic [TW-1:0]   turn_cnt;
  logic [NB-1:0]   tx_sh;
  logic [NB-1:0]   rx_sh;
  logic [NB-1:0]   tx_frame;
  logic [NB-1:0]   rx_next;
  logic            rx_last;

`ifdef HDX_PARITY_EN
  assign tx_frame = {tx_data, ^tx_data};
`else
  assign tx_frame = tx_data;
`endif

  // First sampled bit ends up as the MSB after NB shifts.
  assign rx_next = (rx_sh << 1) | NB'(pad_i);
  assign rx_last = (state == S_SAMPLE) && (bit_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (tx_valid)        state_nx = S_DRIVE;
      S_DRIVE:  if (bit_cnt == '0)   state_nx = S_TURN;
      S_TURN:   if (turn_cnt == '0)  state_nx = S_SAMPLE;
      S_SAMPLE: if (bit_cnt == '0)   state_nx = S_DONE;
      S_DONE:                        state_nx = S_IDLE;
      default:                       state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = 1'b0;
    pad_en   = 1'b0;
    pad_o    = 1'b0;
    rx_valid = 1'b0;
    unique case (state)
      S_IDLE:  tx_ready = 1'b1;
      S_DRIVE: begin
        pad_en = 1'b1;
        pad_o  = tx_sh[NB-1];
      end
      S_DONE:  rx_valid = 1'b1;
      default: ;
    endcase
  end

  // Counters count down to zero so each phase ends on an explicit compare, never a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      turn_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (tx_valid) begin
            tx_sh   <= tx_frame;
            bit_cnt <= NB_LAST;
          end
        end
        S_DRIVE: begin
          tx_sh <= tx_sh << 1;
          if (bit_cnt == '0) turn_cnt <= TURN_LAST;
          else               bit_cnt  <= bit_cnt - 1'b1;
        end
        S_TURN: begin
          if (turn_cnt == '0) bit_cnt  <= NB_LAST;
          else                turn_cnt <= turn_cnt - 1'b1;
        end
        S_SAMPLE: begin
          rx_sh <= rx_next;
          if (rx_last) rx_data <= rx_next[NB-1 -: WIDTH];
          else         bit_cnt <= bit_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HDX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)          rx_err <= 1'b0;
    else if (rx_last) rx_err <= ^rx_next;
  end
`else
  assign rx_err = 1'b0;
`endif

endmodule

// File: tb/tb_hdx_line_ctrl.sv
// Self-checking bench for hdx_line_ctrl: transaction-offset reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_hdx_line_ctrl;
  localparam int W  = 8;
  localparam int TN = 2;
`ifdef HDX_PARITY_EN
  localparam int NB     = W + 1;
  localparam int LAT    = 21;
  localparam int BPER   = 22;
  localparam int NB_LIT = 9;
`else
  localparam int NB     = W;
  localparam int LAT    = 19;
  localparam int BPER   = 20;
  localparam int NB_LIT = 8;
`endif
  localparam int DONE_D = 2 * NB + TN + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         pad_i = 1'b0;
  logic         tx_ready, rx_valid, rx_err, pad_en, pad_o;
  logic [W-1:0] rx_data;

  hdx_line_ctrl #(.WIDTH(W), .TURN(TN)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .pad_en(pad_en), .pad_o(pad_o), .pad_i(pad_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] mk_frame(input logic [31:0] data, input logic bad);
`ifdef HDX_PARITY_EN
    return (data << 1) | {31'b0, (^data) ^ bad};
`else
    return data | {31'b0, bad & 1'b0};
`endif
  endfunction

  // Reference model: transaction position d counts cycles after acceptance.
  logic [31:0] resp_q[$];
  bit          busy = 1'b0;
  bit          armed = 1'b0;
  int          d = 0;
  logic [31:0] txf = '0, rxf = '0, held = '0;
  logic        held_err = 1'b0;

  logic        pado_q[$];
  int          drive_starts[$];
  int          rxv_cyc[$];
  logic [31:0] rxv_data[$];
  logic        rxv_err[$];
  logic        prev_en = 1'b0;

  initial begin
    logic e_en, e_o, e_v;
    forever begin
      @(negedge clk);
      if (armed) begin
        e_en = busy && d >= 1 && d <= NB;
        e_o  = e_en ? txf[NB-d] : 1'b0;
        e_v  = busy && d == DONE_D;
        if (e_v) begin
          held = rxf >> (NB - W);
`ifdef HDX_PARITY_EN
          held_err = ^rxf;
`else
          held_err = 1'b0;
`endif
        end
        check("tx_ready", tx_ready, !busy);
        check("pad_en", pad_en, e_en);
        check("pad_o", pad_o, e_o);
        check("rx_valid", rx_valid, e_v);
        check("rx_data", rx_data, held);
        if (e_v) check("rx_err", rx_err, held_err);
        if (pad_en) pado_q.push_back(pad_o);
        if (pad_en && !prev_en) drive_starts.push_back(cyc);
        if (rx_valid) begin
          rxv_cyc.push_back(cyc);
          rxv_data.push_back(rx_data);
          rxv_err.push_back(rx_err);
        end
      end
      prev_en = pad_en;
      if (busy && d > NB + TN && d <= 2 * NB + TN) pad_i = rxf[2*NB+TN-d];
      else pad_i = cyc[0];
      if (rst) begin
        busy = 1'b0;
        held = '0;
        held_err = 1'b0;
        armed = 1'b1;
      end else if (armed) begin
        if (!busy) begin
          if (tx_valid) begin
            busy = 1'b1;
            d = 1;
            txf = mk_frame({24'b0, tx_data}, 1'b0);
            rxf = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
          end
        end else if (d == DONE_D) busy = 1'b0;
        else d++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    pado_q.delete();
    drive_starts.delete();
    rxv_cyc.delete();
    rxv_data.delete();
    rxv_err.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t = 0;
    while (rxv_cyc.size() < n && t < budget) begin
      tick();
      t++;
    end
    check("rx_timeout", rxv_cyc.size(), n);
  endtask

  function automatic logic [31:0] pack_bits(input int s, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = (v << 1) | {31'b0, (s + i < pado_q.size()) ? pado_q[s+i] : 1'b0};
    return v;
  endfunction

  task automatic start_tx(input logic [7:0] data, output int k);
    tx_data = data;
    tx_valid = 1'b1;
    k = cyc;
    tick();
    tx_valid = 1'b0;
    tx_data = 8'h00;
  endtask

  initial begin
    int k;
    int t;
    repeat (3) begin
      tick();
      check("rst_ready", tx_ready, 1);
      check("rst_pad_en", pad_en, 0);
      check("rst_pad_o", pad_o, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_err", rx_err, 0);
    end
    rst = 1'b0;
    repeat (3) tick();

    // Basic transfer
    clear_caps();
    resp_q.push_back(mk_frame(32'h3C, 1'b0));
    start_tx(8'hA5, k);
    wait_rx(1, 60);
    check("basic_drive_start", (drive_starts.size() > 0) ? drive_starts[0] - k : -1, 1);
    check("basic_en_len", pado_q.size(), NB_LIT);
    check("basic_pado", pack_bits(0, 8), 32'hA5);
    check("basic_lat", (rxv_cyc.size() > 0) ? rxv_cyc[0] - k : -1, LAT);
    check("basic_rx", (rxv_data.size() > 0) ? rxv_data[0] : '1, 32'h3C);
    check("basic_err", (rxv_err.size() > 0) ? rxv_err[0] : 1'b1, 0);

    // Request during TURN is ignored
    repeat (2) tick();
    clear_caps();
    resp_q.push_back(mk_frame(32'hC3, 1'b0));
    start_tx(8'h5A, k);
    repeat (NB) tick();
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    wait_rx(1, 60);
    repeat (4) tick();
    check("ign_starts", drive_starts.size(), 1);
    check("ign_pado", pack_bits(0, 8), 32'h5A);
    check("ign_rx", (rxv_data.size() > 0) ? rxv_data[0] : '1, 32'hC3);
    check("ign_ready", tx_ready, 1);

    // Back-to-back with tx_valid held
    clear_caps();
    resp_q.push_back(mk_frame(32'h81, 1'b0));
    resp_q.push_back(mk_frame(32'h7E, 1'b0));
    tx_data = 8'h01;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'h80;
    t = 0;
    while (drive_starts.size() < 2 && t < 60) begin
      tick();
      t++;
    end
    tx_valid = 1'b0;
    tx_data = 8'h00;
    wait_rx(2, 80);
    repeat (3) tick();
    check("b2b_period", (drive_starts.size() > 1) ? drive_starts[1] - drive_starts[0] : -1, BPER);
    check("b2b_rx_period", (rxv_cyc.size() > 1) ? rxv_cyc[1] - rxv_cyc[0] : -1, BPER);
    check("b2b_pulses", rxv_cyc.size(), 2);
    check("b2b_pado0", pack_bits(0, 8), 32'h01);
    check("b2b_pado1", pack_bits(NB, 8), 32'h80);
    check("b2b_rx0", (rxv_data.size() > 0) ? rxv_data[0] : '1, 32'h81);
    check("b2b_rx1", (rxv_data.size() > 1) ? rxv_data[1] : '1, 32'h7E);

    // Reset in the 4th DRIVE cycle
    clear_caps();
    resp_q.push_back(mk_frame(32'h11, 1'b0));
    start_tx(8'hF0, k);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pad_en", pad_en, 0);
    check("midrst_bits", pado_q.size(), 4);
    repeat (30) tick();
    check("midrst_no_rx", rxv_cyc.size(), 0);
    check("midrst_ready", tx_ready, 1);
    check("midrst_rx_data", rx_data, 0);

    // Reset together with tx_valid
    clear_caps();
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h33;
    tick();
    rst = 1'b0;
    tx_valid = 1'b0;
    repeat (3) tick();
    check("rstv_no_start", drive_starts.size(), 0);
    check("rstv_ready", tx_ready, 1);

`ifdef HDX_PARITY_EN
    clear_caps();
    resp_q.push_back(mk_frame(32'h03, 1'b0));
    start_tx(8'h07, k);
    wait_rx(1, 60);
    check("par_pado", pack_bits(0, 9), 32'h00F);
    check("par_lat0", (rxv_cyc.size() > 0) ? rxv_cyc[0] - k : -1, 21);
    check("par_rx0", (rxv_data.size() > 0) ? rxv_data[0] : '1, 32'h03);
    check("par_err0", (rxv_err.size() > 0) ? rxv_err[0] : 1'b1, 0);
    repeat (2) tick();
    clear_caps();
    resp_q.push_back(mk_frame(32'h03, 1'b1));
    start_tx(8'h07, k);
    wait_rx(1, 60);
    check("par_lat1", (rxv_cyc.size() > 0) ? rxv_cyc[0] - k : -1, 21);
    check("par_rx1", (rxv_data.size() > 0) ? rxv_data[0] : '1, 32'h03);
    check("par_err1", (rxv_err.size() > 0) ? rxv_err[0] : 1'b0, 1);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
